interrupt_controller: RTL and testbench

- Arbitrates the timer interrupt sources: TIFR flags, masked by TIMSK and the SREG I bit.
- At an instruction boundary, sequences the interrupt entry on the shared datapath: push PCL, push PCH, then load the vector, clear the serviced flag and clear I.
- Drives the control unit handshake, the interrupt-stage code consumed by control_mux, and the PC vector input to program memory.

---
 rtl/avr_irq_pkg.sv | 43 ++++
 rtl/irq_priority_encoder.sv | 23 ++
 rtl/interrupt_controller.sv | 159 +++++++++++++++
 tb/tb_interrupt_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_irq_pkg.sv
// Shared definitions for the timer interrupt controller: FSM state encoding,
// interrupt-stage codes, TIFR bit positions, and vector address defaults.
package avr_irq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_PUSHL   = 3'd2,
        ST_PUSHH   = 3'd3,
        ST_VEC     = 3'd4,
        ST_HOLDOFF = 3'd5
    } irq_state_t;

    typedef logic [1:0] stage_t;

    localparam stage_t STAGE_NONE  = 2'd0;
    localparam stage_t STAGE_PUSHL = 2'd1;
    localparam stage_t STAGE_PUSHH = 2'd2;
    localparam stage_t STAGE_VEC   = 2'd3;

    localparam int TIFR_OCF2  = 7;
    localparam int TIFR_TOV2  = 6;
    localparam int TIFR_ICF1  = 5;
    localparam int TIFR_OCF1A = 4;
    localparam int TIFR_OCF1B = 3;
    localparam int TIFR_TOV1  = 2;
    localparam int TIFR_OCF0  = 1;
    localparam int TIFR_TOV0  = 0;

    localparam logic [13:0] VECTOR_BASE_DEF   = 14'h008;
    localparam int          VECTOR_STRIDE_DEF = 2;

    // The top flag bit owns the lowest vector; lower bits step upward.
    function automatic logic [13:0] vector_addr(
        input logic [13:0] base,
        input int          stride,
        input int          top,
        input int          idx
    );
        return base + 14'(stride * (top - idx));
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational highest-set-bit encoder for the pending interrupt vector.
// Ports: req (N flags in), valid (any bit set), idx (index of highest set bit).
module irq_priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Ascending scan: the last hit, i.e. the highest bit, wins.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Timer interrupt arbiter and entry sequencer: request/grant handshake with the
// control unit, PCL/PCH push stages, vector load, flag and I-bit clear strobes.
// Ports: clk, reset (sync, active-high); tifr_in/timsk_in/sreg_i flag inputs;
// instr_done/irq_grant/reti_done from control unit; irq_req, int_stage,
// int_active, sp_dec, mm_we, pc_overwrite, vector, flag_clear, sreg_i_clear out.
module interrupt_controller
    import avr_irq_pkg::*;
#(
    parameter int          NUM_SRC       = 8,
    parameter logic [13:0] VECTOR_BASE   = VECTOR_BASE_DEF,
    parameter int          VECTOR_STRIDE = VECTOR_STRIDE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] tifr_in,
    input  logic [NUM_SRC-1:0] timsk_in,
    input  logic               sreg_i,
    input  logic               instr_done,
    input  logic               irq_grant,
    input  logic               reti_done,
    output logic               irq_req,
    output logic [1:0]         int_stage,
    output logic               int_active,
    output logic               sp_dec,
    output logic               mm_we,
    output logic               pc_overwrite,
    output logic [13:0]        vector,
    output logic [NUM_SRC-1:0] flag_clear,
    output logic               sreg_i_clear
);

    localparam int IDX_W = $clog2(NUM_SRC);

    irq_state_t         state;
    irq_state_t         state_next;
    logic [NUM_SRC-1:0] pend;
    logic               enc_valid;
    logic [IDX_W-1:0]   enc_idx;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   act_idx;
    logic [13:0]        vector_q;
    logic               take;

    assign pend = tifr_in & timsk_in & {NUM_SRC{sreg_i}};

    irq_priority_encoder #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_enc (
        .req   (pend),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Grant is honoured only while requesting and the request still stands.
    assign take = (state == ST_REQ) && !reti_done
                  && enc_valid && irq_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Winner tracks pend while arbitrating; the serviced index is frozen at
    // grant so flags arriving during entry cannot redirect the vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_idx  <= '0;
            act_idx  <= '0;
            vector_q <= '0;
        end else begin
            if (state == ST_IDLE || state == ST_REQ) begin
                win_idx <= enc_idx;
            end
            if (take) begin
                act_idx  <= win_idx;
                vector_q <= vector_addr(VECTOR_BASE, VECTOR_STRIDE,
                                        NUM_SRC - 1, int'(win_idx));
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (reti_done) begin
                    state_next = ST_HOLDOFF;
                end else if (enc_valid) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (reti_done) begin
                    state_next = ST_HOLDOFF;
                end else if (!enc_valid) begin
                    state_next = ST_IDLE;
                end else if (irq_grant) begin
                    state_next = ST_PUSHL;
                end
            end
            ST_PUSHL: state_next = ST_PUSHH;
            ST_PUSHH: state_next = ST_VEC;
            ST_VEC:   state_next = ST_IDLE;
            ST_HOLDOFF: begin
                // A RETI coinciding with the boundary re-arms the holdoff.
                if (reti_done) begin
                    state_next = ST_HOLDOFF;
                end else if (instr_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_req      = 1'b0;
        int_stage    = STAGE_NONE;
        int_active   = 1'b0;
        sp_dec       = 1'b0;
        mm_we        = 1'b0;
        pc_overwrite = 1'b0;
        flag_clear   = '0;
        sreg_i_clear = 1'b0;
        unique case (state)
            ST_REQ: begin
                irq_req = 1'b1;
            end
            ST_PUSHL: begin
                int_stage  = STAGE_PUSHL;
                int_active = 1'b1;
                sp_dec     = 1'b1;
                mm_we      = 1'b1;
            end
            ST_PUSHH: begin
                int_stage  = STAGE_PUSHH;
                int_active = 1'b1;
                sp_dec     = 1'b1;
                mm_we      = 1'b1;
            end
            ST_VEC: begin
                int_stage    = STAGE_VEC;
                int_active   = 1'b1;
                pc_overwrite = 1'b1;
                flag_clear   = NUM_SRC'(1) << act_idx;
                sreg_i_clear = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign vector = vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus
// randomized traffic compared against a behavioural reference model.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tifr;
    logic [7:0]  timsk;
    logic        sreg_i;
    logic        instr_done;
    logic        irq_grant;
    logic        reti_done;
    logic        irq_req;
    logic [1:0]  int_stage;
    logic        int_active;
    logic        sp_dec;
    logic        mm_we;
    logic        pc_overwrite;
    logic [13:0] vector;
    logic [7:0]  flag_clear;
    logic        sreg_i_clear;

    int checks = 0;
    int errors = 0;

    // Reference model: "requesting", "in holdoff", entry step 0..3,
    // remembered winner and the vector chosen at the last accepted grant.
    bit          m_req = 0;
    bit          m_hold = 0;
    int          m_stage = 0;
    int          m_win = 0;
    int          m_lat = 0;
    logic [13:0] m_vec = '0;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk          (clk),
        .reset        (reset),
        .tifr_in      (tifr),
        .timsk_in     (timsk),
        .sreg_i       (sreg_i),
        .instr_done   (instr_done),
        .irq_grant    (irq_grant),
        .reti_done    (reti_done),
        .irq_req      (irq_req),
        .int_stage    (int_stage),
        .int_active   (int_active),
        .sp_dec       (sp_dec),
        .mm_we        (mm_we),
        .pc_overwrite (pc_overwrite),
        .vector       (vector),
        .flag_clear   (flag_clear),
        .sreg_i_clear (sreg_i_clear)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [13:0] vec_of(input int idx);
        return 14'(8 + 2 * (7 - idx));
    endfunction

    task automatic model_step();
        logic [7:0] p;
        bit         arb;
        int         old_win;
        p       = tifr & timsk & {8{sreg_i}};
        arb     = !m_hold && m_stage == 0;
        old_win = m_win;
        if (reset) begin
            m_req = 0; m_hold = 0; m_stage = 0;
            m_win = 0; m_lat = 0; m_vec = '0;
            return;
        end
        if (m_stage != 0) begin
            m_stage = (m_stage == 3) ? 0 : m_stage + 1;
        end else if (reti_done) begin
            m_hold = 1;
            m_req  = 0;
        end else if (m_hold) begin
            if (instr_done) m_hold = 0;
        end else if (m_req) begin
            if (p == 0) begin
                m_req = 0;
            end else if (irq_grant) begin
                m_req   = 0;
                m_stage = 1;
                m_lat   = old_win;
                m_vec   = vec_of(old_win);
            end
        end else if (p != 0) begin
            m_req = 1;
        end
        if (arb) m_win = top_bit(p);
    endtask

    task automatic compare();
        bit push;
        bit load;
        push = (m_stage == 1) || (m_stage == 2);
        load = (m_stage == 3);
        check("irq_req",      32'(irq_req),      32'(m_req));
        check("int_stage",    32'(int_stage),    32'(m_stage));
        check("int_active",   32'(int_active),   32'(m_stage != 0));
        check("mm_we",        32'(mm_we),        32'(push));
        check("sp_dec",       32'(sp_dec),       32'(push));
        check("pc_overwrite", 32'(pc_overwrite), 32'(load));
        check("sreg_i_clear", 32'(sreg_i_clear), 32'(load));
        check("vector",       32'(vector),       32'(m_vec));
        check("flag_clear",   32'(flag_clear),
              load ? 32'(8'(1) << m_lat) : 32'd0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset = 1; tifr = 0; timsk = 0; sreg_i = 0;
        instr_done = 0; irq_grant = 0; reti_done = 0;
        cycle();
        cycle();
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_vec", 32'(vector), 32'd0);
        reset = 0;

        // basic entry on OCF1A
        tifr = 8'h10; timsk = 8'h10; sreg_i = 1;
        cycle();
        check("t1_req", 32'(irq_req), 32'd1);
        irq_grant = 1;
        cycle();
        irq_grant = 0;
        check("t1_s1", 32'(int_stage), 32'd1);
        cycle();
        check("t1_s2", 32'(int_stage), 32'd2);
        cycle();
        check("t1_s3", 32'(int_stage), 32'd3);
        check("t1_vec", 32'(vector), 32'h00E);
        check("t1_fc", 32'(flag_clear), 32'h10);
        check("t1_ic", 32'(sreg_i_clear), 32'd1);
        tifr = 0; sreg_i = 0;
        cycle();
        check("t1_end", 32'(int_stage), 32'd0);

        // masked by TIMSK, then by I
        tifr = 8'h01; timsk = 8'h00; sreg_i = 1;
        for (int n = 0; n < 10; n++) begin
            irq_grant = n[0];
            cycle();
        end
        check("mask_timsk", 32'(irq_req), 32'd0);
        timsk = 8'h01; sreg_i = 0;
        for (int n = 0; n < 10; n++) begin
            irq_grant = n[0];
            cycle();
        end
        irq_grant = 0;
        check("mask_i", 32'(irq_req), 32'd0);
        check("mask_stage", 32'(int_stage), 32'd0);

        // simultaneous flags: bit 4 beats bits 1 and 0
        tifr = 8'h13; timsk = 8'hFF; sreg_i = 1;
        cycle();
        irq_grant = 1;
        cycle();
        irq_grant = 0;
        cycle();
        cycle();
        check("pri_vec", 32'(vector), 32'h00E);
        check("pri_fc", 32'(flag_clear), 32'h10);
        tifr = 8'h03; sreg_i = 0;
        cycle();
        check("pri_idle", 32'(irq_req), 32'd0);
        tifr = 0;

        // withdrawal before grant
        tifr = 8'h01; timsk = 8'h01; sreg_i = 1;
        cycle();
        check("wd_req", 32'(irq_req), 32'd1);
        tifr = 0;
        cycle();
        check("wd_drop", 32'(irq_req), 32'd0);
        irq_grant = 1;
        cycle();
        irq_grant = 0;
        check("wd_nostage", 32'(int_stage), 32'd0);
        cycle();
        check("wd_inactive", 32'(int_active), 32'd0);

        // RETI holdoff with TOV0 pending
        tifr = 8'h01; timsk = 8'h01; sreg_i = 1; reti_done = 1;
        cycle();
        reti_done = 0;
        for (int n = 0; n < 5; n++) cycle();
        check("ho_req0", 32'(irq_req), 32'd0);
        instr_done = 1; reti_done = 1;
        cycle();
        instr_done = 0; reti_done = 0;
        cycle();
        check("ho_restart", 32'(irq_req), 32'd0);
        instr_done = 1;
        cycle();
        instr_done = 0;
        check("ho_exit", 32'(irq_req), 32'd0);
        cycle();
        check("ho_req1", 32'(irq_req), 32'd1);
        irq_grant = 1;
        cycle();
        irq_grant = 0;
        cycle();
        cycle();
        check("ho_vec", 32'(vector), 32'h016);
        check("ho_fc", 32'(flag_clear), 32'h01);
        tifr = 0; sreg_i = 0;
        cycle();

        // reset during PUSHH
        tifr = 8'h10; timsk = 8'h10; sreg_i = 1;
        cycle();
        irq_grant = 1;
        cycle();
        irq_grant = 0;
        cycle();
        check("rm_pushh", 32'(int_stage), 32'd2);
        reset = 1;
        cycle();
        check("rm_stage", 32'(int_stage), 32'd0);
        check("rm_fc", 32'(flag_clear), 32'd0);
        check("rm_vec", 32'(vector), 32'd0);
        check("rm_we", 32'(mm_we), 32'd0);
        reset = 0;
        cycle();
        check("rm_rereq", 32'(irq_req), 32'd1);

        // randomized traffic; flags/I follow the clear strobes the model expects
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            irq_grant  = ($urandom_range(0, 2) == 0);
            instr_done = ($urandom_range(0, 3) == 0);
            reti_done  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 5) == 0)
                tifr = tifr | (8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0)
                tifr = tifr & 8'($urandom);
            if ($urandom_range(0, 31) == 0)
                timsk = 8'($urandom);
            if ($urandom_range(0, 9) == 0 || reti_done)
                sreg_i = 1;
            cycle();
            if (m_stage == 3) begin
                tifr[m_lat] = 1'b0;
                sreg_i = 0;
            end
        end
        reset = 0; irq_grant = 0; instr_done = 0; reti_done = 0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
